// File: rtl/cr16_mem_pkg.sv
// Shared constants for the CR16 memory-side stage: I/O word addresses and
// the bridge state encoding.
package cr16_mem_pkg;

  localparam logic [15:0] IO_SW  = 16'hFF00;
  localparam logic [15:0] IO_LED = 16'hFF01;
  localparam logic [15:0] IO_CNT = 16'hFF02;
  localparam logic [15:0] IO_HEX = 16'hFF03;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/io_reg_bank.sv
// Memory-mapped I/O registers: switch synchroniser, LED and hex registers,
// free-running cycle counter, and the combinational read mux.
module io_reg_bank
  import cr16_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SW_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] led,
  output logic [DATA_W-1:0] hex
);

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [DATA_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led     <= '0;
      hex     <= '0;
      cnt     <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (wr_en && addr == IO_LED) led <= wdata;
      if (wr_en && addr == IO_HEX) hex <= wdata;
      // A write to the counter clears it, taking priority over the increment.
      if (wr_en && addr == IO_CNT) cnt <= '0;
      else                         cnt <= cnt + DATA_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      IO_SW:   rd_data = DATA_W'(sw_sync);
      IO_LED:  rd_data = led;
      IO_CNT:  rd_data = cnt;
      IO_HEX:  rd_data = hex;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-side stage: steers the fetch or data address to block RAM or the
// I/O registers, sequences RAM read latency and pulses ready on completion.
module mem_io_bridge
  import cr16_mem_pkg::*;
#(
  parameter int              DATA_W  = 16,
  parameter int              RAM_AW  = 14,
  parameter logic [DATA_W-1:0] IO_BASE = 16'hFF00,
  parameter int              SW_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mem_s,
  input  logic              mem_wr_s,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] led,
  output logic [DATA_W-1:0] hex,
  output logic [1:0]        dbg_state
);

  // Handshake: req is accepted only in IDLE (busy low); each accepted req
  // yields exactly one single-cycle ready pulse, and req while busy is dropped.
  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;
  logic              is_io;
  logic              io_we;
  logic [DATA_W-1:0] io_rdata;

  assign is_io     = (a_q >= IO_BASE);
  assign ram_addr  = a_q[RAM_AW-1:0];
  assign ram_din   = wd_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      wd_q  <= '0;
      we_q  <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        a_q  <= mem_s ? pc : daddr;
        wd_q <= wdata;
        // A store on the fetch path is illegal: flag it and perform a read.
        we_q <= mem_wr_s & ~mem_s;
        if (mem_s && mem_wr_s) err <= 1'b1;
      end
      if (state == ACCESS && !we_q && is_io) rdata <= io_rdata;
      if (state == WAIT)                     rdata <= ram_dout;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    io_we     = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          ram_we    = ~is_io;
          io_we     = is_io;
          state_nxt = DONE;
        end else begin
          state_nxt = is_io ? DONE : WAIT;
        end
      end
      WAIT: state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  io_reg_bank #(
    .DATA_W(DATA_W),
    .SW_W  (SW_W)
  ) u_io (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (io_we),
    .addr   (a_q),
    .wdata  (wd_q),
    .sw     (sw),
    .rd_data(io_rdata),
    .led    (led),
    .hex    (hex)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a behavioural synchronous block RAM.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, mem_s, mem_wr_s;
  logic [15:0] pc, daddr, wdata;
  logic [15:0] rdata;
  logic        ready, busy, err;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [9:0]  sw;
  logic [15:0] led, hex;
  logic [1:0]  dbg_state;

  logic [15:0] ram_mem [0:16383];

  int errors = 0;
  int checks = 0;
  int lat, wec, rdc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  mem_io_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mem_s    (mem_s),
    .mem_wr_s (mem_wr_s),
    .pc       (pc),
    .daddr    (daddr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .busy     (busy),
    .err      (err),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .sw       (sw),
    .led      (led),
    .hex      (hex),
    .dbg_state(dbg_state)
  );

  // One access; latency counts negedges after the sampling edge until ready.
  task automatic access(input logic ms, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input bit hold);
    @(negedge clk);
    mem_s = ms; mem_wr_s = wr; wdata = wd; req = 1'b1;
    if (ms) pc = a; else daddr = a;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    lat = 0; wec = 0; rdc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_we) wec++;
      if (ready) begin
        rdc++;
        if (lat == 0) lat = i;
        req = 1'b0;
        if (!hold) break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; mem_s = 1'b0; mem_wr_s = 1'b0;
    pc = '0; daddr = '0; wdata = '0; sw = 10'h2AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    checks++; if ({ready, busy, err, ram_we} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {ready, busy, err, ram_we}); end
    checks++; if ({led, hex} !== 32'h0) begin errors++; $display("FAIL reset_io: got %h want 00000000", {led, hex}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
  endtask

  task automatic test_fetch_read();
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL fetch_rdata: got %h want A5C3", rdata); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL fetch_we: got %0d want 0", wec); end
  endtask

  task automatic test_data_write_read();
    access(1'b0, 1'b1, 16'h0200, 16'h1234, 1'b0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
    checks++; if (wec !== 1) begin errors++; $display("FAIL write_we_cycles: got %0d want 1", wec); end
    checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL write_keeps_rdata: got %h want A5C3", rdata); end
    checks++; if (ram_addr !== 14'h0200) begin errors++; $display("FAIL write_addr_held: got %h want 0200", ram_addr); end
    access(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL read_rdata: got %h want 1234", rdata); end
  endtask

  task automatic test_alias();
    access(1'b0, 1'b0, 16'h4010, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL alias_rdata: got %h want A5C3", rdata); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL alias_latency: got %0d want 3", lat); end
  endtask

  task automatic test_io();
    access(1'b0, 1'b1, 16'hFF01, 16'h00FF, 1'b0);
    checks++; if (led !== 16'h00FF) begin errors++; $display("FAIL io_led: got %h want 00FF", led); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL io_write_no_ram_we: got %0d want 0", wec); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL io_write_latency: got %0d want 2", lat); end
    access(1'b0, 1'b0, 16'hFF00, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'h02AA) begin errors++; $display("FAIL io_sw: got %h want 02AA", rdata); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL io_read_latency: got %0d want 2", lat); end
    access(1'b0, 1'b1, 16'hFF03, 16'h1B3C, 1'b0);
    checks++; if (hex !== 16'h1B3C) begin errors++; $display("FAIL io_hex: got %h want 1B3C", hex); end
    access(1'b0, 1'b1, 16'hFF05, 16'hBEEF, 1'b0);
    checks++; if ({led, hex} !== 32'h00FF_1B3C) begin errors++; $display("FAIL io_unmapped_write: got %h want 00FF1B3C", {led, hex}); end
    access(1'b0, 1'b0, 16'hFF01, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'h00FF) begin errors++; $display("FAIL io_led_readback: got %h want 00FF", rdata); end
    access(1'b0, 1'b0, 16'hFF05, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL io_unmapped_read: got %h want 0000", rdata); end
  endtask

  task automatic test_counter();
    // Clear, then read five cycles after the write request: ACCESS sees count 4.
    access(1'b0, 1'b1, 16'hFF02, 16'h5555, 1'b0);
    repeat (2) @(negedge clk);
    access(1'b0, 1'b0, 16'hFF02, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'h0004) begin errors++; $display("FAIL counter_after_clear: got %h want 0004", rdata); end
    @(negedge clk);
    force dut.u_io.cnt = 16'hFFFF;
    #1;
    release dut.u_io.cnt;
    @(negedge clk);
    checks++; if (dut.u_io.cnt !== 16'h0000) begin errors++; $display("FAIL counter_wrap: got %h want 0000", dut.u_io.cnt); end
    access(1'b0, 1'b0, 16'hFF02, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'h0002) begin errors++; $display("FAIL counter_after_wrap: got %h want 0002", rdata); end
  endtask

  task automatic test_hazards();
    access(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1);
    checks++; if (rdc !== 1) begin errors++; $display("FAIL busy_req_ready_count: got %0d want 1", rdc); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL busy_req_rdata: got %h want 1234", rdata); end
    access(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b0);
    checks++; if (wec !== 0) begin errors++; $display("FAIL fetch_write_we: got %0d want 0", wec); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fetch_write_err: got %b want 1", err); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL fetch_write_latency: got %0d want 3", lat); end
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL fetch_write_ram_intact: got %h want A5C3", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_access();
    int late_ready;
    @(negedge clk);
    mem_s = 1'b0; mem_wr_s = 1'b0; daddr = 16'h0200; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL pre_reset_state: got %0d want 2", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
    checks++; if ({ready, busy, ram_we} !== 3'b0) begin errors++; $display("FAIL abort_flags: got %b want 000", {ready, busy, ram_we}); end
    checks++; if ({led, hex, rdata} !== 48'h0) begin errors++; $display("FAIL abort_regs: got %h want 0", {led, hex, rdata}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err); end
    reset = 1'b1;
    late_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) late_ready++;
    end
    checks++; if (late_ready !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d want 0", late_ready); end
  endtask

  initial begin
    ram_mem[16'h0010] = 16'hA5C3;
    test_reset();
    test_fetch_read();
    test_data_write_read();
    test_alias();
    test_io();
    test_counter();
    test_hazards();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
